// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first.
// Operands are captured on an accepted start; results are held until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             br_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             a0;
    logic             b0;
    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    // Single full-subtractor cell working on the current LSBs.
    always_comb begin
        a0    = a_q[0];
        b0    = b_q[0];
        bit_d = a0 ^ b0 ^ br_q;
        br_d  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        res_d = {bit_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= bin_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Final bit: publish the result on the same edge so done follows start by WIDTH cycles.
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=4 and WIDTH=8 instances against an arithmetic model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       bin4, bin8;
    logic       busy4, done4, bout4;
    logic       busy8, done8, bout8;
    logic [3:0] diff4;
    logic [7:0] diff8;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4), .bin_i(bin4),
        .busy_o(busy4), .done_o(done4), .diff_o(diff4), .bout_o(bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
        .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[6];

    // Reference: plain integer arithmetic, result {bout, diff}.
    function automatic logic [8:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
        int ia, ib, ibin, r;
        logic [8:0] res;
        ia   = a;
        ib   = b;
        ibin = bin;
        r    = ia - ib - ibin;
        res[7:0] = 8'(r & ((1 << w) - 1));
        res[8]   = (r < 0);
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero4(input string name);
        check({name, ".busy"}, {31'b0, busy4}, 32'd0);
        check({name, ".done"}, {31'b0, done4}, 32'd0);
        check({name, ".diff"}, {28'b0, diff4}, 32'd0);
        check({name, ".bout"}, {31'b0, bout4}, 32'd0);
    endtask

    // One operation with exact cycle-by-cycle handshake checks.
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input bit scramble, input logic [8:0] exp);
        int w;
        w = w8 ? 8 : 4;
        if (w8) begin
            a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; bin4 = bin; start4 = 1'b1;
        end
        tick();
        start4 = 1'b0;
        start8 = 1'b0;
        check("busy_after_start", {31'b0, w8 ? busy8 : busy4}, 32'd1);
        check("done_after_start", {31'b0, w8 ? done8 : done4}, 32'd0);
        for (int i = 1; i <= w; i++) begin
            if (scramble) begin
                a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            tick();
            if (i < w) begin
                check("busy_run", {31'b0, w8 ? busy8 : busy4}, 32'd1);
                check("done_run", {31'b0, w8 ? done8 : done4}, 32'd0);
            end else begin
                check("busy_done", {31'b0, w8 ? busy8 : busy4}, 32'd0);
                check("done_pulse", {31'b0, w8 ? done8 : done4}, 32'd1);
                check("diff", {24'b0, w8 ? diff8 : {4'b0, diff4}}, {24'b0, exp[7:0]});
                check("bout", {31'b0, w8 ? bout8 : bout4}, {31'b0, exp[8]});
            end
        end
        tick();
        check("done_width", {31'b0, w8 ? done8 : done4}, 32'd0);
        check("diff_hold", {24'b0, w8 ? diff8 : {4'b0, diff4}}, {24'b0, exp[7:0]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] e;
        logic [3:0] ops_a[24];
        logic [3:0] ops_b[24];
        logic       ops_bin[24];
        logic [3:0] exp_diff;
        logic       exp_bout;
        logic [7:0] ra, rb;
        logic       rbin;

        vecs[0] = '{4'b0110, 4'b0011, 1'b0, 4'b0011, 1'b0};
        vecs[1] = '{4'b0010, 4'b0100, 1'b0, 4'b1110, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
        vecs[3] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0};
        vecs[4] = '{4'b1000, 4'b0001, 1'b1, 4'b0110, 1'b0};
        vecs[5] = '{4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b1};

        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; bin4 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check_zero4("idle");
        end

        for (int i = 0; i < 6; i++)
            run_op(1'b0, {4'b0, vecs[i].a}, {4'b0, vecs[i].b}, vecs[i].bin, 1'b0, {vecs[i].bout, 4'b0, vecs[i].diff});

        // Operand changes during RUN must not disturb the captured values.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15)); rbin = 1'($urandom);
            run_op(1'b0, ra, rb, rbin, 1'b1, ref_sub(4, ra, rb, rbin));
        end

        // start held for 20 cycles: accepts every 6 edges, done 4 edges after each accept.
        exp_diff = diff4;
        exp_bout = bout4;
        for (int ed = 0; ed < 24; ed++) begin
            start4 = (ed < 20);
            ops_a[ed] = 4'($urandom); ops_b[ed] = 4'($urandom); ops_bin[ed] = 1'($urandom);
            a4 = ops_a[ed]; b4 = ops_b[ed]; bin4 = ops_bin[ed];
            tick();
            if (ed % 6 == 4) begin
                e = ref_sub(4, {4'b0, ops_a[ed-4]}, {4'b0, ops_b[ed-4]}, ops_bin[ed-4]);
                exp_diff = e[3:0];
                exp_bout = e[8];
            end
            check("held_done", {31'b0, done4}, {31'b0, (ed % 6 == 4)});
            check("held_busy", {31'b0, busy4}, {31'b0, (ed % 6 < 4)});
            check("held_diff", {28'b0, diff4}, {28'b0, exp_diff});
            check("held_bout", {31'b0, bout4}, {31'b0, exp_bout});
        end
        start4 = 1'b0;
        tick();

        // Reset two cycles into an operation aborts it.
        a4 = 4'b1001; b4 = 4'b0010; bin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero4("abort");
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", {31'b0, done4}, 32'd0);
            check("abort_no_busy", {31'b0, busy4}, 32'd0);
        end
        run_op(1'b0, 8'b1000, 8'b1101, 1'b0, 1'b0, {1'b1, 8'b0000_1011});

        // rst and start together: reset wins.
        rst = 1'b1; start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
        tick();
        rst = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_zero4("rst_start");
        end

        run_op(1'b1, 8'h00, 8'h01, 1'b0, 1'b0, {1'b1, 8'hFF});
        run_op(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, {1'b0, 8'hFE});
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            run_op(1'b1, ra, rb, rbin, 1'b1, ref_sub(8, ra, rb, rbin));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing a − b − bin one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse-direction counterpart of the combinational ripple-carry adder. It uses a single full-subtractor cell and a registered borrow in place of WIDTH chained adder cells, trading latency for area. Results are held on registered outputs until the next operation completes, so a bench or downstream block can sample them at leisure.

## Interface
- WIDTH, 4, operand and difference width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; diff/bout valid from this cycle on
- diff  output  WIDTH  registered difference
- bout  output  1  registered borrow-out

## Operation
- Single clock `clk`; reset `rst` is synchronous and active-high.
- Result definition: diff = (a − b − bin) mod 2^WIDTH; bout = 1 iff a < b + bin (unsigned).
- FSM states:
  - IDLE: start=1 → capture a, b and bin into shift registers/borrow flop; clear bit counter; go to RUN.
  - RUN: each cycle consume LSBs a0 and b0 with borrow br.
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - Shift d into the internal result register from the MSB side; shift operands right; increment counter.
    - After the WIDTH-th bit, go to DONE.
  - DONE: load diff ← internal result and bout ← final br; done=1; go to IDLE next cycle.
- start is ignored in RUN and DONE; there is no queueing.
- Changes on a, b or bin after capture have no effect on the operation in flight.
- diff and bout change only on entry to DONE; between operations they hold the last result.
- Reset (any state, including mid-RUN): state ← IDLE; busy, done, diff, bout and the counter ← 0. An aborted operation never produces done.
- Simultaneous rst and start: rst wins; start is not accepted.

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0.
- start sampled high at edge k, in IDLE:
  - busy=1 after edges k … k+WIDTH−1, i.e. WIDTH cycles.
  - Bits 0 … WIDTH−1 are processed on edges k+1 … k+WIDTH.
  - done=1 and diff/bout are updated after edge k+WIDTH.
  - done=0 and state=IDLE after edge k+WIDTH+1.
- Latency from start edge to done: WIDTH cycles.
- Maximum throughput: one operation per WIDTH+2 cycles with start held high; the next start is accepted at edge k+WIDTH+2.
- busy and done are never high in the same cycle. done is exactly one cycle wide.

## Test plan
- Reset, then idle for 5 cycles → busy=0, done=0, diff=0000, bout=0 throughout.
- WIDTH=4; a=0110, b=0011, bin=0; one-cycle start → busy high for 4 cycles; done pulses 4 cycles after the start edge; diff=0011, bout=0.
- WIDTH=4 underflow cases:
  - a=0010, b=0100, bin=0 → diff=1110, bout=1.
  - a=0000, b=0000, bin=1 → diff=1111, bout=1.
  - a=1111, b=1111, bin=0 → diff=0000, bout=0.
- Input stability: change a and b to random values every cycle while busy → result matches the captured operands. Hold start high for 20 cycles → one done every 6 cycles, and prior diff is held between pulses.
- Reset mid-operation: assert rst 2 cycles after start → no done, outputs 0. Then a=1000, b=1101, bin=0 → diff=1011, bout=1.
- WIDTH=8, 200 random {a, b, bin} → every done matches a−b−bin mod 256 and bout = (a < b+bin). Boundary case a=00, b=01 → diff=FF, bout=1.
